// File: rtl/l1_instr_pkg.sv
// Sizes, FSM encoding and small helpers shared by the L1 instruction fetch controller.
package l1_instr_pkg;
  localparam int block_size  = 128;
  localparam int tag_size    = 9;
  localparam int idx_size    = 6;
  localparam int word_size   = 2;
  localparam int offset_size = 2;
  localparam int addr_w      = tag_size + idx_size + word_size + offset_size;
  localparam int blk_w       = tag_size + idx_size;
  localparam logic [addr_w-1:0] reset_pc_default = '0;

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, REQ, WAIT, FILL, DELIVER} state_t;

  function automatic logic is_compressed(input logic [15:0] hw);
    return (hw & 16'h0003) != 16'h0003;
  endfunction

  function automatic logic [blk_w-1:0] next_blk(input logic [blk_w-1:0] blk);
    return blk + blk_w'(1);
  endfunction
endpackage

// File: rtl/l1_instr_fetch_ctrl_refill.sv
// L2 refill handshake: block address register, refill data capture and saturating miss counter.
module l1_instr_refill
  import l1_instr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [blk_w-1:0]      start_blk,
  input  logic                  active,
  input  logic                  l2_valid,
  input  logic [block_size-1:0] l2_data,
  output logic                  l2_req,
  output logic [blk_w-1:0]      l2_addr,
  output logic                  done,
  output logic [block_size-1:0] block,
  output logic [15:0]           miss_cnt
);

  logic [blk_w-1:0] blk_q;

  assign l2_req  = active;
  assign l2_addr = active ? blk_q : '0;
  assign done    = active & l2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q    <= '0;
      block    <= '0;
      miss_cnt <= '0;
    end else begin
      if (start) blk_q <= start_blk;
      if (done) begin
        block <= l2_data;
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/l1_instr_fetch_ctrl.sv
// Fetch controller between the L1 I-cache, the L2 refill port and the core.
// state   | meaning
// IDLE    | fetch disabled, waiting for fetch_en_i
// LOOKUP  | cache read of pc
// CHECK   | cache result sampled: hit, miss or next-block miss
// REQ     | first cycle of L2 request
// WAIT    | holding L2 request until l2_valid_i
// FILL    | writing captured block into the cache
// DELIVER | instruction offered to the core
module l1_instr_fetch_ctrl
  import l1_instr_pkg::*;
#(
  parameter logic [addr_w-1:0] reset_pc = reset_pc_default
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_en_i,
  input  logic                  redirect_i,
  input  logic [addr_w-1:0]     redirect_pc_i,
  output logic [31:0]           instr_o,
  output logic [addr_w-1:0]     instr_pc_o,
  output logic                  instr_compressed_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic                  cache_read_o,
  output logic                  cache_write_o,
  output logic                  cache_write_next_o,
  output logic [addr_w-1:0]     cache_addr_o,
  output logic [block_size-1:0] cache_data_L2_o,
  input  logic [31:0]           cache_data_i,
  input  logic                  cache_hit_i,
  input  logic                  cache_miss_next_i,
  output logic                  l2_req_o,
  output logic [blk_w-1:0]      l2_addr_o,
  input  logic                  l2_valid_i,
  input  logic [block_size-1:0] l2_data_i,
  output logic [15:0]           miss_cnt_o
);

  state_t state, state_nxt;
  logic [addr_w-1:0] pc, pc_nxt, pend_pc, redir_pc, pc_step;
  logic pend_valid, nxt_q, in_refill, cur_c;
  logic refill_start, refill_done;
  logic [blk_w-1:0] pc_blk, start_blk;
  logic [31:0] data_q;
  logic [block_size-1:0] block;

  assign redir_pc  = redirect_pc_i & ~addr_w'(1);
  assign pc_blk    = pc[addr_w-1 -: blk_w];
  assign cur_c     = is_compressed(data_q[15:0]);
  assign pc_step   = pc + (cur_c ? addr_w'(2) : addr_w'(4));
  assign in_refill = (state == REQ) || (state == WAIT) || (state == FILL);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    refill_start = 1'b0;
    start_blk    = pc_blk;
    // A redirect outside a refill wins over everything, including a handshake.
    if (redirect_i && !in_refill) begin
      pc_nxt    = redir_pc;
      state_nxt = fetch_en_i ? LOOKUP : IDLE;
    end else begin
      case (state)
        IDLE:    if (fetch_en_i) state_nxt = LOOKUP;
        LOOKUP:  state_nxt = CHECK;
        CHECK: begin
          if (!cache_hit_i || cache_miss_next_i) begin
            state_nxt    = REQ;
            refill_start = 1'b1;
            start_blk    = cache_hit_i ? next_blk(pc_blk) : pc_blk;
          end else begin
            state_nxt = DELIVER;
          end
        end
        REQ:     state_nxt = refill_done ? FILL : WAIT;
        WAIT:    if (refill_done) state_nxt = FILL;
        FILL: begin
          state_nxt = LOOKUP;
          if (redirect_i)      pc_nxt = redir_pc;
          else if (pend_valid) pc_nxt = pend_pc;
        end
        DELIVER: begin
          if (instr_ready_i) begin
            pc_nxt    = pc_step;
            state_nxt = fetch_en_i ? LOOKUP : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc         <= reset_pc;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      nxt_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      pc <= pc_nxt;
      if (state == CHECK) data_q <= cache_data_i;
      if (refill_start)   nxt_q  <= cache_hit_i;
      if (state == FILL) begin
        pend_valid <= 1'b0;
      end else if (in_refill && redirect_i) begin
        pend_pc    <= redir_pc;
        pend_valid <= 1'b1;
      end
    end
  end

  l1_instr_refill u_refill (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .start     (refill_start),
    .start_blk (start_blk),
    .active    ((state == REQ) || (state == WAIT)),
    .l2_valid  (l2_valid_i),
    .l2_data   (l2_data_i),
    .l2_req    (l2_req_o),
    .l2_addr   (l2_addr_o),
    .done      (refill_done),
    .block     (block),
    .miss_cnt  (miss_cnt_o)
  );

  assign cache_addr_o       = pc;
  assign cache_read_o       = (state == LOOKUP);
  assign cache_write_o      = (state == FILL);
  assign cache_write_next_o = (state == FILL) && nxt_q;
  assign cache_data_L2_o    = (state == FILL) ? block : '0;
  assign instr_valid_o      = (state == DELIVER);
  assign instr_compressed_o = (state == DELIVER) && cur_c;
  assign instr_o            = (state != DELIVER) ? 32'h0 :
                              cur_c ? {16'h0, data_q[15:0]} : data_q;
  assign instr_pc_o         = pc;

endmodule

// File: tb/tb_l1_instr_fetch_ctrl.sv
// Directed bench for l1_instr_fetch_ctrl with a behavioural direct-mapped I-cache and L2 responder.
module tb_l1_instr_fetch_ctrl;
  import l1_instr_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i, fetch_en_i, redirect_i, instr_ready_i;
  logic [addr_w-1:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [addr_w-1:0] instr_pc_o, cache_addr_o;
  logic instr_compressed_o, instr_valid_o;
  logic cache_read_o, cache_write_o, cache_write_next_o;
  logic [block_size-1:0] cache_data_L2_o, l2_data_i = '0;
  logic [31:0] cache_data_i = '0;
  logic cache_hit_i = 1'b0, cache_miss_next_i = 1'b0;
  logic l2_req_o, l2_valid_i = 1'b0;
  logic [blk_w-1:0] l2_addr_o;
  logic [15:0] miss_cnt_o;

  int tests = 0, fails = 0;
  int l2_lat = 2, l2_cnt = 0;
  logic flush = 1'b1;

  always #5 clk_i = ~clk_i;

  l1_instr_fetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_en_i(fetch_en_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_compressed_o(instr_compressed_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .cache_read_o(cache_read_o), .cache_write_o(cache_write_o),
    .cache_write_next_o(cache_write_next_o), .cache_addr_o(cache_addr_o),
    .cache_data_L2_o(cache_data_L2_o), .cache_data_i(cache_data_i), .cache_hit_i(cache_hit_i),
    .cache_miss_next_i(cache_miss_next_i), .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o),
    .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i), .miss_cnt_o(miss_cnt_o)
  );

  function automatic logic [127:0] l2_block(input logic [14:0] a);
    case (a)
      15'h0000: l2_block = {16'h0017, 16'h0014, 16'h0012, 16'h001F,
                            16'h000B, 16'h0004, 16'h001E, 16'h0003};
      15'h0001: l2_block = {112'h0, 16'hFFFF};
      15'h7FFF: l2_block = {16'h1233, 112'h0};
      default:  l2_block = {8{16'hA5A7}};
    endcase
  endfunction

  // Direct-mapped cache model; results registered one cycle after a read.
  logic [127:0] c_mem [64];
  logic [8:0]   c_tag [64];
  logic [63:0]  c_val;
  logic [14:0]  m_blk, m_nblk;
  logic [2:0]   m_hw;
  logic         m_hit, m_nhit;
  logic [15:0]  m_lo, m_hi;

  always @(posedge clk_i) begin
    m_blk  = cache_addr_o[18:4];
    m_nblk = m_blk + 15'd1;
    m_hw   = cache_addr_o[3:1];
    m_hit  = c_val[m_blk[5:0]] && (c_tag[m_blk[5:0]] == m_blk[14:6]);
    m_nhit = c_val[m_nblk[5:0]] && (c_tag[m_nblk[5:0]] == m_nblk[14:6]);
    m_lo   = c_mem[m_blk[5:0]][int'(m_hw)*16 +: 16];
    m_hi   = (m_hw == 3'd7) ? c_mem[m_nblk[5:0]][15:0] : c_mem[m_blk[5:0]][(int'(m_hw)+1)*16 +: 16];
    if (flush) begin
      c_val <= '0;
    end else begin
      if (cache_read_o) begin
        cache_hit_i       <= m_hit;
        cache_miss_next_i <= m_hit && (m_hw == 3'd7) && !m_nhit;
        cache_data_i      <= {m_hi, m_lo};
      end
      if (cache_write_o) begin
        if (cache_write_next_o) begin
          c_mem[m_nblk[5:0]] <= cache_data_L2_o;
          c_tag[m_nblk[5:0]] <= m_nblk[14:6];
          c_val[m_nblk[5:0]] <= 1'b1;
        end else begin
          c_mem[m_blk[5:0]] <= cache_data_L2_o;
          c_tag[m_blk[5:0]] <= m_blk[14:6];
          c_val[m_blk[5:0]] <= 1'b1;
        end
      end
    end
  end

  // L2 responder: one-cycle valid pulse l2_lat cycles into a request.
  always @(negedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      l2_valid_i <= 1'b0;
      l2_cnt     <= 0;
    end else begin
      l2_valid_i <= 1'b0;
      if (l2_req_o && !l2_valid_i) begin
        if (l2_cnt >= l2_lat) begin
          l2_valid_i <= 1'b1;
          l2_data_i  <= l2_block(l2_addr_o);
          l2_cnt     <= 0;
        end else begin
          l2_cnt <= l2_cnt + 1;
        end
      end else begin
        l2_cnt <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       sel = l2_req_o;
      1:       sel = cache_write_o;
      default: sel = instr_valid_o;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sel(which)) break;
      tick();
    end
    check(tag, 128'(sel(which)), 128'd1);
  endtask

  task automatic take(input logic [31:0] ei, input logic [18:0] ep, input logic ec, input string tag);
    wait_sig(2, {tag, "_valid"});
    check({tag, "_instr"}, 128'(instr_o), 128'(ei));
    check({tag, "_pc"}, 128'(instr_pc_o), 128'(ep));
    check({tag, "_comp"}, 128'(instr_compressed_o), 128'(ec));
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; fetch_en_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0;
    redirect_pc_i = '0;
    repeat (3) tick();
    flush = 1'b0;
    check("rst_pc", 128'(instr_pc_o), 128'h0);
    check("rst_valid", 128'(instr_valid_o), 128'h0);
    check("rst_req", 128'(l2_req_o), 128'h0);
    check("rst_read", 128'(cache_read_o), 128'h0);
    check("rst_cnt", 128'(miss_cnt_o), 128'h0);

    // Cold miss, then reset while waiting on L2.
    rst_i = 1'b1;
    tick();
    fetch_en_i = 1'b1; l2_lat = 10;
    tick();
    check("lookup_read", 128'(cache_read_o), 128'h1);
    check("lookup_addr", 128'(cache_addr_o), 128'h0);
    tick();
    tick();
    check("req_level", 128'(l2_req_o), 128'h1);
    check("req_addr", 128'(l2_addr_o), 128'h0);
    tick();
    rst_i = 1'b0;
    #1;
    check("async_req_drop", 128'(l2_req_o), 128'h0);
    check("async_pc", 128'(instr_pc_o), 128'h0);
    tick();
    rst_i = 1'b1; l2_lat = 2;

    wait_sig(0, "cold_req");
    check("cold_l2_addr", 128'(l2_addr_o), 128'h0);
    wait_sig(1, "cold_fill");
    check("cold_wnext", 128'(cache_write_next_o), 128'h0);
    check("cold_fill_data", cache_data_L2_o, l2_block(15'h0));
    tick();
    check("fill_one_cycle", 128'(cache_write_o), 128'h0);
    check("fill_then_lookup", 128'(cache_read_o), 128'h1);
    take(32'h001E0003, 19'h0, 1'b0, "i0");
    check("cnt_one", 128'(miss_cnt_o), 128'h1);
    take(32'h00000004, 19'h4, 1'b1, "i4");
    take(32'h001F000B, 19'h6, 1'b0, "i6");
    take(32'h00000012, 19'hA, 1'b1, "i10");
    take(32'h00000014, 19'hC, 1'b1, "i12");

    // Straddle at pc=14 needs the next block.
    wait_sig(0, "strad_req");
    check("strad_l2_addr", 128'(l2_addr_o), 128'h1);
    wait_sig(1, "strad_fill");
    check("strad_wnext", 128'(cache_write_next_o), 128'h1);
    take(32'hFFFF0017, 19'hE, 1'b0, "i14");
    check("pc_after_14", 128'(instr_pc_o), 128'h12);
    check("cnt_two", 128'(miss_cnt_o), 128'h2);

    // Redirect beats a same-cycle handshake.
    wait_sig(2, "i18_valid");
    check("i18_instr", 128'(instr_o), 128'h0);
    check("i18_comp", 128'(instr_compressed_o), 128'h1);
    redirect_i = 1'b1; redirect_pc_i = 19'h40; instr_ready_i = 1'b1;
    tick();
    redirect_i = 1'b0; instr_ready_i = 1'b0;
    check("redir_valid_drop", 128'(instr_valid_o), 128'h0);
    check("redir_pc", 128'(instr_pc_o), 128'h40);

    // Redirect during a refill is held until the fill completes.
    l2_lat = 4;
    wait_sig(0, "r40_req");
    check("r40_l2_addr", 128'(l2_addr_o), 128'h4);
    tick();
    check("r40_waiting", 128'(l2_req_o), 128'h1);
    redirect_i = 1'b1; redirect_pc_i = 19'h00101;
    tick();
    redirect_i = 1'b0;
    check("pend_pc_held", 128'(instr_pc_o), 128'h40);
    check("pend_no_valid", 128'(instr_valid_o), 128'h0);
    wait_sig(1, "pend_fill");
    check("pend_fill_addr", 128'(cache_addr_o), 128'h40);
    tick();
    check("pend_lookup", 128'(cache_read_o), 128'h1);
    check("pend_lookup_addr", 128'(cache_addr_o), 128'h100);
    check("pend_lookup_nv", 128'(instr_valid_o), 128'h0);

    // Back-pressure: outputs and pc hold while ready is low.
    wait_sig(2, "stall_valid");
    for (int i = 0; i < 5; i++) begin
      check("stall_instr", 128'(instr_o), 128'hA5A7A5A7);
      check("stall_pc", 128'(instr_pc_o), 128'h100);
      check("stall_valid_hold", 128'(instr_valid_o), 128'h1);
      tick();
    end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    check("one_adv_pc", 128'(instr_pc_o), 128'h104);
    check("one_adv_nv", 128'(instr_valid_o), 128'h0);
    wait_sig(2, "i104_valid");
    check("i104_pc", 128'(instr_pc_o), 128'h104);
    check("cnt_four", 128'(miss_cnt_o), 128'h4);
    fetch_en_i = 1'b0; instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    tick();
    tick();
    check("idle_pc", 128'(instr_pc_o), 128'h108);
    check("idle_no_read", 128'(cache_read_o), 128'h0);
    check("idle_no_valid", 128'(instr_valid_o), 128'h0);

    // Address wrap: straddle from the top block into block 0.
    rst_i = 1'b0; flush = 1'b1;
    tick();
    tick();
    flush = 1'b0; rst_i = 1'b1;
    check("rst2_cnt", 128'(miss_cnt_o), 128'h0);
    redirect_i = 1'b1; redirect_pc_i = 19'h7FFFF;
    tick();
    redirect_i = 1'b0;
    check("wrap_redir_pc", 128'(instr_pc_o), 128'h7FFFE);
    check("wrap_idle", 128'(cache_read_o), 128'h0);
    fetch_en_i = 1'b1; l2_lat = 1;
    wait_sig(0, "wrap_req1");
    check("wrap_l2_addr1", 128'(l2_addr_o), 128'h7FFF);
    wait_sig(1, "wrap_fill1");
    check("wrap_wnext1", 128'(cache_write_next_o), 128'h0);
    wait_sig(0, "wrap_req2");
    check("wrap_l2_addr2", 128'(l2_addr_o), 128'h0);
    wait_sig(1, "wrap_fill2");
    check("wrap_wnext2", 128'(cache_write_next_o), 128'h1);
    take(32'h00031233, 19'h7FFFE, 1'b0, "iwrap");
    check("wrap_next_pc", 128'(instr_pc_o), 128'h2);
    check("wrap_cnt", 128'(miss_cnt_o), 128'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l1_instr_fetch_ctrl.md
Name: l1_instr_fetch_ctrl

Overview:
Fetch controller directly downstream of the L1 instruction cache; sole driver of its read/write/write_next/address/refill-data inputs. Walks the PC, consumes cache data_o/hit_o/miss_next_o, splits 16-bit compressed from 32-bit instructions, and advances the PC by 2 or 4. Services misses and next-block (straddle) misses with a req/valid handshake to L2. Delivers instructions to the core over a valid/ready interface and accepts PC redirects.

Parameters:
block_size, 128, cache block width in bits
tag_size, 9, tag bits
idx_size, 6, index bits
word_size, 2, word-select bits
offset_size, 2, byte-offset bits
addr_w, tag_size+idx_size+word_size+offset_size (19), fetch address width
reset_pc, 0, PC loaded on reset

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
fetch_en_i  in  1  core enables fetching
redirect_i  in  1  one-cycle PC redirect pulse
redirect_pc_i  in  addr_w  redirect target; bit 0 forced to 0
instr_o  out  32  instruction; compressed = {16'b0, hw}
instr_pc_o  out  addr_w  PC of instr_o
instr_compressed_o  out  1  instr_o is 16-bit
instr_valid_o  out  1  instr_o valid
instr_ready_i  in  1  core accepts instr_o
cache_read_o  out  1  to cache read_i
cache_write_o  out  1  to cache write_i
cache_write_next_o  out  1  to cache write_next_i
cache_addr_o  out  addr_w  to cache addr_i
cache_data_L2_o  out  block_size  to cache data_L2_i
cache_data_i  in  32  from cache data_o
cache_hit_i  in  1  from cache hit_o
cache_miss_next_i  in  1  from cache miss_next_o
l2_req_o  out  1  L2 refill request, level
l2_addr_o  out  tag_size+idx_size  block address requested
l2_valid_i  in  1  L2 data valid, one-cycle pulse
l2_data_i  in  block_size  L2 block
miss_cnt_o  out  16  saturating count of L2 refills

Behaviour:
- Reset (rst_i low, async): state IDLE, pc=reset_pc, all outputs 0 except instr_pc_o=reset_pc; l2_req_o drops immediately; a pending L2 transfer is abandoned; L2 must also be reset.
- cache_addr_o = pc in every state. Cache outputs are sampled in the cycle after cache_read_o=1.
- IDLE: wait for fetch_en_i=1, then LOOKUP.
- LOOKUP (1 cycle): cache_read_o=1, then CHECK.
- CHECK: hit=0 -> REQ, blk={pc tag,idx}, nxt=0. hit=1 and miss_next=1 -> REQ, blk={pc tag,idx}+1 (wraps modulo 2^(tag+idx)), nxt=1. hit=1 and miss_next=0 -> latch data, DELIVER.
- REQ/WAIT: l2_req_o=1, l2_addr_o=blk, held until the l2_valid_i cycle; capture l2_data_i; miss_cnt_o+1, saturates at 0xFFFF; go FILL.
- FILL (1 cycle): cache_write_o=1, cache_write_next_o=nxt, cache_data_L2_o=captured block, addr=pc; then LOOKUP.
- Refill latency = L2 latency + 3 cycles to the next CHECK.
- DELIVER: instr_valid_o=1, instr_pc_o=pc. Compressed when data[1:0]!=2'b11: instr_o={16'b0,data[15:0]}, instr_compressed_o=1, else data[31:0].
- On instr_valid_o & instr_ready_i: pc += 2 (compressed) or 4, mod 2^addr_w. fetch_en_i=1 -> LOOKUP the next cycle, else IDLE.
- Outputs hold stable while instr_ready_i=0.
- redirect_i in IDLE/LOOKUP/CHECK/DELIVER: pc=redirect_pc_i&~1, instr_valid_o=0 next cycle, then LOOKUP (IDLE if fetch_en_i=0). Redirect beats handshake in the same cycle.
- redirect_i in REQ/WAIT/FILL: target latched in a pending register; refill completes and is written; LOOKUP then uses the pending PC. A later redirect overwrites the pending one.
- fetch_en_i=0 only stops new lookups from IDLE/DELIVER; an in-flight refill completes.
- L2 and cache write strobes are never asserted in the same cycle as cache_read_o.

Decomposition:
- Package l1_instr_pkg: size parameters and defaults, derived addr_w and blk width, FSM state enum (IDLE, LOOKUP, CHECK, REQ, WAIT, FILL, DELIVER), function is_compressed(hw), function next_blk(blk).
- Sub-module l1_instr_refill: REQ/WAIT handshake, block capture register and miss counter.
- The top holds PC, redirect pending register and FSM.

Test Plan:
- Reset low mid-WAIT -> l2_req_o=0 same cycle, instr_pc_o=reset_pc=0. Release, fetch_en_i=1, cold miss -> l2_addr_o=0, one cycle of cache_write_o after l2_valid_i, then hit, miss_cnt_o=1.
- Block at idx 0/tag 0 with halfwords {0003,001E,0004,000B,001F,0012,0014,0017} -> instrs 001E0003@0, 00000004@4 (c), 001F000B@6, 00000012@10 (c), 00000014@12 (c).
- Continue at pc=14: miss_next -> l2_addr_o=1; next block lower halfword FFFF; FILL with cache_write_next_o=1 -> instr FFFF0017@14, nc, pc becomes 18.
- redirect_i to 0x00101 during WAIT -> refill still written; next LOOKUP addr=0x00100; no instr_valid_o with the old PC.
- instr_ready_i low 5 cycles in DELIVER -> instr_o/instr_pc_o stable, pc unchanged; one-cycle ready -> exactly one advance.
- pc=0x7FFFE straddling, miss_next -> l2_addr_o=0 (wrap); delivered PC 0x7FFFE; next pc=0x00002 (nc).
